// File: rtl/rfifo_uart_send.sv
// Return path of the UART-SDRAM loopback: drains one burst of BURST_LEN bytes
// from the read FIFO per rd_done event and hands them to uart_tx one at a time.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   rd_done         - pulse: a full burst has landed in rfifo
//   rfifo_empty     - rfifo empty flag
//   rfifo_rd_data   - rfifo read data, valid the cycle after rfifo_rd_en
//   rfifo_rd_en     - rfifo read strobe (one-cycle pulse)
//   tx_busy         - uart_tx is shifting a byte
//   tx_done         - pulse from uart_tx at end of stop bit
//   tx_trig         - one-cycle start pulse to uart_tx
//   tx_data         - byte to uart_tx, stable from tx_trig until tx_done
//   send_busy       - high from burst start until the last byte's tx_done
module rfifo_uart_send #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned PEND_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_done,
    input  logic       rfifo_empty,
    input  logic [7:0] rfifo_rd_data,
    output logic       rfifo_rd_en,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_trig,
    output logic [7:0] tx_data,
    output logic       send_busy
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        TRIG    = 3'd3,
        TX_WAIT = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [PEND_W-1:0]  pend, pend_nxt;
    logic [7:0]         tx_data_nxt;
    logic               start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            pend      <= '0;
            tx_data   <= 8'h00;
            send_busy <= 1'b0;
        end else begin
            byte_cnt  <= byte_cnt_nxt;
            pend      <= pend_nxt;
            tx_data   <= tx_data_nxt;
            send_busy <= (state_nxt != IDLE);
        end
    end

    // Next state and strobes; rd_en and trig react in-cycle to empty/busy
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        tx_data_nxt  = tx_data;
        rfifo_rd_en  = 1'b0;
        tx_trig      = 1'b0;
        start        = 1'b0;

        case (state)
            IDLE: begin
                if ((pend != '0) || rd_done) begin
                    start        = 1'b1;
                    byte_cnt_nxt = '0;
                    state_nxt    = RD_REQ;
                end
            end
            RD_REQ: begin
                // Underflow wait has no timeout
                if (!rfifo_empty) begin
                    rfifo_rd_en = 1'b1;
                    state_nxt   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                tx_data_nxt = rfifo_rd_data;
                state_nxt   = TRIG;
            end
            TRIG: begin
                if (!tx_busy) begin
                    tx_trig   = 1'b1;
                    state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_done) begin
                    if (byte_cnt == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        byte_cnt_nxt = byte_cnt + CNT_W'(1);
                        state_nxt    = RD_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Keep strobes quiet while reset is being applied
        if (rst) begin
            rfifo_rd_en = 1'b0;
            tx_trig     = 1'b0;
        end
    end

    // Pending-burst counter: saturating, simultaneous inc/dec cancels
    always_comb begin
        pend_nxt = pend;
        if (rd_done && !start) begin
            if (pend != PEND_MAX) begin
                pend_nxt = pend + PEND_W'(1);
            end
        end else if (start && !rd_done) begin
            pend_nxt = pend - PEND_W'(1);
        end
    end

endmodule

// File: tb/tb_rfifo_uart_send.sv
// Directed bench for rfifo_uart_send with an rfifo model and a uart_tx model.
module tb_rfifo_uart_send;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_done = 1'b0;
    logic       rfifo_empty;
    logic [7:0] rfifo_rd_data = 8'h00;
    logic       rfifo_rd_en;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       send_busy;

    int n_checks = 0;
    int n_fail   = 0;

    rfifo_uart_send #(.BURST_LEN(4), .PEND_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_done       (rd_done),
        .rfifo_empty   (rfifo_empty),
        .rfifo_rd_data (rfifo_rd_data),
        .rfifo_rd_en   (rfifo_rd_en),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_trig       (tx_trig),
        .tx_data       (tx_data),
        .send_busy     (send_busy)
    );

    always #5 clk = ~clk;

    // rfifo model: standard-mode FIFO, data appears the cycle after rd_en
    logic [7:0]  fifo_mem [0:63];
    int unsigned push_cnt = 0;
    int unsigned pop_cnt  = 0;
    int unsigned underflow_cnt = 0;
    logic        fifo_flush = 1'b0;
    assign rfifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_flush) begin
            pop_cnt <= push_cnt;
        end else if (rfifo_rd_en) begin
            if (push_cnt == pop_cnt) begin
                underflow_cnt <= underflow_cnt + 1;
            end else begin
                rfifo_rd_data <= fifo_mem[pop_cnt[5:0]];
                pop_cnt       <= pop_cnt + 1;
            end
        end
    end

    // uart_tx model: busy 10 cycles per byte, tx_done as busy drops
    logic       model_busy = 1'b0;
    logic       force_busy = 1'b0;
    int         bcnt = 0;
    logic [7:0] held = 8'h00;
    assign tx_busy = model_busy | force_busy;

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (model_busy) begin
            if (bcnt == 1) begin
                model_busy <= 1'b0;
                tx_done    <= 1'b1;
            end
            bcnt <= bcnt - 1;
        end else if (tx_trig) begin
            model_busy <= 1'b1;
            bcnt       <= 10;
            held       <= tx_data;
        end
    end

    // Monitor: log transmitted bytes, count strobes, watch tx_data stability
    logic [7:0]  trig_log [0:255];
    int unsigned trig_cnt = 0;
    int unsigned rd_en_cnt = 0;
    int unsigned unstable_cnt = 0;

    always @(posedge clk) begin
        if (tx_trig) begin
            trig_log[trig_cnt[7:0]] <= tx_data;
            trig_cnt <= trig_cnt + 1;
        end
        if (rfifo_rd_en) rd_en_cnt <= rd_en_cnt + 1;
        if (model_busy && (tx_data !== held)) unstable_cnt <= unstable_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[push_cnt[5:0]] = b;
        push_cnt = push_cnt + 1;
    endtask

    task automatic pulse_rd_done();
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
    endtask

    task automatic wait_trigs(input int unsigned target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (trig_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!send_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rfifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", rfifo_rd_en); end
        n_checks++;
        if (tx_trig !== 1'b0) begin n_fail++; $display("FAIL reset_tx_trig: got %0b expected 0", tx_trig); end
        n_checks++;
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %0h expected 00", tx_data); end
        n_checks++;
        if (send_busy !== 1'b0) begin n_fail++; $display("FAIL reset_send_busy: got %0b expected 0", send_busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({send_busy, rfifo_rd_en, tx_trig} !== 3'b000) begin
            n_fail++; $display("FAIL reset_quiet: got %0b expected 000", {send_busy, rfifo_rd_en, tx_trig});
        end
    endtask

    task automatic test_single_burst();
        int unsigned bt = trig_cnt, br = rd_en_cnt, bu = unstable_cnt;
        int done_n = 0, last_done = -10, fall = -1;
        for (int i = 0; i < 4; i++) push(8'((i + 1) * 17));
        pulse_rd_done();
        n_checks++;
        if (rfifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en_latency: got %0b expected 1", rfifo_rd_en); end
        n_checks++;
        if (send_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %0b expected 1", send_busy); end
        @(negedge clk);
        n_checks++;
        if (rfifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_rd_en_width: got %0b expected 0", rfifo_rd_en); end
        @(negedge clk);
        n_checks++;
        if ({tx_trig, tx_data} !== {1'b1, 8'h11}) begin
            n_fail++; $display("FAIL single_trig_latency: got trig=%0b data=%0h expected trig=1 data=11", tx_trig, tx_data);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_done) begin done_n++; last_done = i; end
            if (!send_busy) begin fall = i; break; end
        end
        n_checks++;
        if (done_n != 4) begin n_fail++; $display("FAIL single_done_count: got %0d expected 4", done_n); end
        n_checks++;
        if (fall != last_done + 1) begin
            n_fail++; $display("FAIL single_busy_fall: got cycle %0d expected %0d", fall, last_done + 1);
        end
        n_checks++;
        if (trig_cnt - bt != 4) begin n_fail++; $display("FAIL single_trig_count: got %0d expected 4", trig_cnt - bt); end
        n_checks++;
        if (rd_en_cnt - br != 4) begin n_fail++; $display("FAIL single_rd_en_count: got %0d expected 4", rd_en_cnt - br); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (trig_log[8'(bt + i)] !== 8'((i + 1) * 17)) begin
                n_fail++; $display("FAIL single_byte%0d: got %0h expected %0h", i, trig_log[8'(bt + i)], 8'((i + 1) * 17));
            end
        end
        n_checks++;
        if (unstable_cnt != bu) begin n_fail++; $display("FAIL single_data_stable: got %0d changes expected 0", unstable_cnt - bu); end
    endtask

    task automatic test_back_to_back();
        int unsigned bt = trig_cnt;
        int gap = 0, d;
        bit done = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'hA1 + i));
        pulse_rd_done();
        repeat (4) @(negedge clk);
        pulse_rd_done();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            d = int'(trig_cnt - bt);
            if (d >= 1 && d < 8 && !send_busy) gap++;
            if (d == 8 && !send_busy) begin done = 1'b1; break; end
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %0d bytes expected 8", trig_cnt - bt); end
        n_checks++;
        if (gap != 1) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d cycles expected 1", gap); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (trig_log[8'(bt + i)] !== 8'(8'hA1 + i)) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %0h expected %0h", i, trig_log[8'(bt + i)], 8'(8'hA1 + i));
            end
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if ({send_busy, 32'(trig_cnt - bt)} !== {1'b0, 32'd8}) begin
            n_fail++; $display("FAIL b2b_pending_clear: got busy=%0b bytes=%0d expected busy=0 bytes=8", send_busy, trig_cnt - bt);
        end
    endtask

    task automatic test_empty_stall();
        int unsigned bt = trig_cnt, br = rd_en_cnt;
        int stall_en = 0;
        bit ok;
        pulse_rd_done();
        for (int i = 0; i < 20; i++) begin
            if (rfifo_rd_en) stall_en++;
            @(negedge clk);
        end
        n_checks++;
        if (stall_en != 0) begin n_fail++; $display("FAIL stall_rd_en: got %0d strobes expected 0", stall_en); end
        n_checks++;
        if (send_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %0b expected 1", send_busy); end
        for (int i = 0; i < 4; i++) push(8'(8'hC1 + i));
        #1;
        n_checks++;
        if (rfifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %0b expected 1", rfifo_rd_en); end
        @(negedge clk);
        wait_trigs(bt + 4, 300, ok);
        if (ok) wait_idle(50, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: got %0d bytes expected 4", trig_cnt - bt); end
        n_checks++;
        if (rd_en_cnt - br != 4) begin n_fail++; $display("FAIL stall_rd_en_count: got %0d expected 4", rd_en_cnt - br); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (trig_log[8'(bt + i)] !== 8'(8'hC1 + i)) begin
                n_fail++; $display("FAIL stall_byte%0d: got %0h expected %0h", i, trig_log[8'(bt + i)], 8'(8'hC1 + i));
            end
        end
    endtask

    task automatic test_backpressure();
        int unsigned bt = trig_cnt, bu = unstable_cnt;
        int early = 0, wobble = 0;
        bit ok;
        for (int i = 0; i < 4; i++) push(8'(8'hD1 + i));
        force_busy = 1'b1;
        pulse_rd_done();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (tx_trig) early++;
            if (tx_data !== 8'hD1) wobble++;
            @(negedge clk);
        end
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL bp_trig_while_busy: got %0d pulses expected 0", early); end
        n_checks++;
        if (wobble != 0) begin n_fail++; $display("FAIL bp_data_hold: got %0d bad cycles expected 0", wobble); end
        force_busy = 1'b0;
        #1;
        n_checks++;
        if ({tx_trig, tx_data} !== {1'b1, 8'hD1}) begin
            n_fail++; $display("FAIL bp_trig_release: got trig=%0b data=%0h expected trig=1 data=d1", tx_trig, tx_data);
        end
        @(negedge clk);
        wait_trigs(bt + 4, 300, ok);
        if (ok) wait_idle(50, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got %0d bytes expected 4", trig_cnt - bt); end
        n_checks++;
        if (trig_log[8'(bt + 3)] !== 8'hD4) begin n_fail++; $display("FAIL bp_last_byte: got %0h expected d4", trig_log[8'(bt + 3)]); end
        n_checks++;
        if (unstable_cnt != bu) begin n_fail++; $display("FAIL bp_data_stable: got %0d changes expected 0", unstable_cnt - bu); end
    endtask

    task automatic test_reset_mid_burst();
        int unsigned bt = trig_cnt, br;
        bit ok;
        for (int i = 0; i < 4; i++) push(8'(8'hE1 + i));
        pulse_rd_done();
        wait_trigs(bt + 2, 200, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_timeout: got %0d bytes expected 2", trig_cnt - bt); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rfifo_rd_en, tx_trig, send_busy, tx_data} !== 11'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got rd_en=%0b trig=%0b busy=%0b data=%0h expected all 0",
                               rfifo_rd_en, tx_trig, send_busy, tx_data);
        end
        rst = 1'b0;
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        bt = trig_cnt;
        br = rd_en_cnt;
        repeat (50) @(negedge clk);
        n_checks++;
        if (rd_en_cnt - br != 0) begin n_fail++; $display("FAIL rstmid_rd_en_after: got %0d expected 0", rd_en_cnt - br); end
        n_checks++;
        if (trig_cnt - bt != 0) begin n_fail++; $display("FAIL rstmid_trig_after: got %0d expected 0", trig_cnt - bt); end
        n_checks++;
        if (send_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %0b expected 0", send_busy); end
    endtask

    task automatic test_saturation();
        int unsigned bt = trig_cnt, br = rd_en_cnt, bf = underflow_cnt;
        bit ok;
        for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
        pulse_rd_done();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pulse_rd_done();
            repeat (2) @(negedge clk);
        end
        wait_trigs(bt + 16, 1500, ok);
        if (ok) wait_idle(50, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_timeout: got %0d bytes expected 16", trig_cnt - bt); end
        repeat (60) @(negedge clk);
        n_checks++;
        if (trig_cnt - bt != 16) begin n_fail++; $display("FAIL sat_byte_count: got %0d expected 16", trig_cnt - bt); end
        n_checks++;
        if (rd_en_cnt - br != 16) begin n_fail++; $display("FAIL sat_rd_en_count: got %0d expected 16", rd_en_cnt - br); end
        n_checks++;
        if (underflow_cnt != bf) begin n_fail++; $display("FAIL sat_underflow: got %0d expected 0", underflow_cnt - bf); end
        for (int i = 0; i < 16; i += 5) begin
            n_checks++;
            if (trig_log[8'(bt + i)] !== 8'(8'h50 + i)) begin
                n_fail++; $display("FAIL sat_byte%0d: got %0h expected %0h", i, trig_log[8'(bt + i)], 8'(8'h50 + i));
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_empty_stall();
        test_backpressure();
        test_reset_mid_burst();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rfifo_uart_send.md
Name: rfifo_uart_send

Overview:
- Return path of the UART–SDRAM loopback. It drains the read FIFO (rfifo) that the SDRAM controller fills after each read burst, and hands the bytes one at a time to uart_tx.
- One read command (0xAA) produces one burst of BURST_LEN bytes. This block serialises that burst to the UART transmitter, with a byte handshake and back-pressure.
- Sits between the rfifo read port and uart_tx.

Parameters:
- BURST_LEN, 4, bytes sent per rd_done event. Must match the write-burst length on the decode side.
- PEND_W, 2, width of the pending-burst counter. Saturates at 2^PEND_W-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rd_done  input  1  one-cycle pulse from SDRAM controller: a full burst has been written into rfifo
- rfifo_empty  input  1  rfifo empty flag
- rfifo_rd_data  input  8  rfifo read data, valid 1 cycle after rfifo_rd_en (standard-mode FIFO)
- rfifo_rd_en  output  1  rfifo read strobe, one-cycle pulse
- tx_busy  input  1  high while uart_tx is shifting a byte
- tx_done  input  1  one-cycle pulse from uart_tx at end of stop bit
- tx_trig  output  1  one-cycle start pulse to uart_tx
- tx_data  output  8  byte to uart_tx, held stable from tx_trig until tx_done
- send_busy  output  1  high from burst start until the last byte's tx_done

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, byte counter 0, pending counter 0. A reset mid-burst abandons the burst. No further rfifo_rd_en or tx_trig until a new rd_done.
- Pending counter:
  - +1 on rd_done.
  - -1 when a burst is started, i.e. on the IDLE->RD_REQ transition.
  - rd_done and start in the same cycle: net 0.
  - Saturates at max; extra rd_done is dropped.
- FSM states:
  - IDLE: send_busy=0. If pending>0 or rd_done, go to RD_REQ, clear byte_cnt, and set send_busy=1 from the next cycle.
  - RD_REQ:
    - If rfifo_empty=1, stay. No rd_en; this is an underflow wait with no timeout.
    - Else assert rfifo_rd_en for exactly 1 cycle and go to RD_WAIT.
  - RD_WAIT: one cycle. Capture rfifo_rd_data into tx_data, go to TRIG.
  - TRIG: wait for tx_busy=0. Then pulse tx_trig for 1 cycle and go to TX_WAIT.
  - TX_WAIT: on tx_done:
    - byte_cnt==BURST_LEN-1: go to IDLE. send_busy drops the cycle after tx_done.
    - otherwise: byte_cnt+1, go to RD_REQ.
- Latency: rd_done (rfifo non-empty, uart idle) to tx_trig is 3 cycles (RD_REQ, RD_WAIT, TRIG). tx_done to the next rfifo_rd_en is 1 cycle.
- Byte order is FIFO order. No header or framing bytes are added.
- byte_cnt width: clog2(BURST_LEN), minimum 1. Never wraps mid-burst.
- tx_data holds its last value in IDLE. It changes only in RD_WAIT.
- tx_done seen outside TX_WAIT is ignored.
- rd_done arriving mid-burst is only counted. The current burst is unaffected, and the next burst starts right after the current one returns to IDLE (IDLE lasts 1 cycle).

Test Plan:
- Single burst: preload rfifo 0x11,0x22,0x33,0x44, pulse rd_done, uart model busy 10 cycles per byte.
  - Expect tx_trig ×4 with tx_data 0x11,0x22,0x33,0x44 in order.
  - Expect exactly 4 rfifo_rd_en pulses.
  - Expect send_busy to fall 1 cycle after the 4th tx_done.
- Back-to-back: preload 8 bytes, pulse rd_done twice 5 cycles apart.
  - Expect 8 bytes out in order and pending back to 0.
  - Expect a 1-cycle IDLE gap between the bursts.
- Empty stall: rd_done with rfifo empty for 20 cycles, then push 4 bytes.
  - Expect rfifo_rd_en=0 during the stall.
  - Expect the first rd_en in the cycle empty deasserts, then normal transmission.
- Busy back-pressure: tx_busy held 1 when TRIG is entered.
  - Expect tx_trig only in the cycle after tx_busy falls.
  - Expect tx_data stable throughout.
- Reset mid-burst: assert rst after the 2nd tx_trig.
  - Expect all outputs 0 next cycle and state IDLE.
  - Expect no rd_en or tx_trig for 50 cycles without rd_done.
- Saturation (PEND_W=2): 5 rd_done pulses during one burst.
  - Expect pending to cap at 3.
  - Expect exactly 4 bursts transmitted in total.
